// File: rtl/square_iterate.sv
// ---------------------------------------------------------------------------
// square_iterate
//
// Iterative squarer for the 16-bit unpacked floating-point path. It accepts
// an operand that has already been split into sign, unbiased exponent,
// 11-bit mantissa and class flags. It squares the mantissa with an 11-step
// shift-add loop and then renormalises the product. The result is returned
// on the same field/flag bundle that the sqrt unit produces, so the
// downstream packing logic can be shared between the two units.
//
// Special operands (NaN, +/-Inf, zero/subnormal) are resolved on the
// accepting edge without iterating.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   enable       clock enable; when low, every register holds
//   n_valid      operand present; accepted only while idle
//   is_nan_in    operand is NaN
//   is_pinf_in   operand is +Inf
//   is_ninf_in   operand is -Inf
//   is_num       operand is finite (zero, subnormal or normal)
//   sign_in      operand sign
//   exp_in       signed unbiased exponent (-15 zero/subnormal, 16 Inf/NaN)
//   mant_in      mantissa; bit 10 integer bit, bit 9 NaN quiet bit
//   it_valid     unit busy, or has just accepted an operand
//   result       one-cycle pulse; output fields are final
//   sign_out     result sign
//   exp_out      result signed unbiased exponent
//   mant_out     result mantissa
//   is_nan_out   result is NaN
//   is_pinf_out  result is +Inf
//   is_ninf_out  result is -Inf (a square never is, so this stays 0)
//
// States
//   ST_IDLE | waiting for an operand; n_valid starts a new operation
//   ST_BUSY | shift-add iteration in progress; n_valid is ignored
// ---------------------------------------------------------------------------
module square_iterate (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               n_valid,
    input  logic               is_nan_in,
    input  logic               is_pinf_in,
    input  logic               is_ninf_in,
    input  logic               is_num,
    input  logic               sign_in,
    input  logic signed [6:0]  exp_in,
    input  logic [10:0]        mant_in,
    output logic               it_valid,
    output logic               result,
    output logic               sign_out,
    output logic signed [6:0]  exp_out,
    output logic [10:0]        mant_out,
    output logic               is_nan_out,
    output logic               is_pinf_out,
    output logic               is_ninf_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0]        ITER_STEPS = 4'd11;
    localparam logic signed [6:0] EXP_ZERO   = -7'sd15;
    localparam logic signed [6:0] EXP_SPEC   = 7'sd16;
    localparam logic [10:0]       MANT_ONE   = 11'b100_0000_0000;
    localparam logic [10:0]       QUIET_BIT  = 11'b010_0000_0000;

    state_t             state, state_nxt;
    logic [3:0]         iter, iter_nxt;
    logic [21:0]        mcand, mcand_nxt;
    logic [10:0]        mplier, mplier_nxt;
    logic [21:0]        acc, acc_nxt;
    logic signed [6:0]  exp_lat, exp_lat_nxt;

    logic               it_valid_nxt;
    logic               result_nxt;
    logic               sign_out_nxt;
    logic signed [6:0]  exp_out_nxt;
    logic [10:0]        mant_out_nxt;
    logic               is_nan_out_nxt;
    logic               is_pinf_out_nxt;

    logic               start;
    logic               op_nan;
    logic               op_inf;
    logic               op_zero;
    logic [21:0]        partial;
    logic [21:0]        prod;
    logic [10:0]        mant_norm;
    logic signed [7:0]  e_sq;

    // Operand classification. A non-finite operand with no class flag set
    // is treated as NaN so that a malformed bundle never looks numeric.
    assign start   = enable & n_valid & (state == ST_IDLE);
    assign op_nan  = is_nan_in | (~is_num & ~is_pinf_in & ~is_ninf_in);
    assign op_inf  = is_pinf_in | is_ninf_in;
    assign op_zero = (exp_in == EXP_ZERO);

    // The multiplicand is kept pre-shifted, so its alignment to the current
    // step is implicit. On the last step, prod already includes that step's
    // partial product, which lets the result be registered on the same edge.
    assign partial = mplier[0] ? mcand : 22'd0;
    assign prod    = acc + partial;

    // Normalisation: a 1.x * 1.x product lies in [1, 4). Bit 21 selects the
    // window and adds one to the doubled exponent. The low bits are
    // truncated. The exponent is carried in 8 bits so that the doubled
    // range never wraps before the range checks.
    always_comb begin
        if (prod[21]) begin
            mant_norm = prod[21:11];
        end else begin
            mant_norm = prod[20:10];
        end
        e_sq = signed'({exp_lat, 1'b0}) + signed'({7'd0, prod[21]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        iter_nxt        = iter;
        mcand_nxt       = mcand;
        mplier_nxt      = mplier;
        acc_nxt         = acc;
        exp_lat_nxt     = exp_lat;
        it_valid_nxt    = it_valid;
        result_nxt      = result;
        sign_out_nxt    = sign_out;
        exp_out_nxt     = exp_out;
        mant_out_nxt    = mant_out;
        is_nan_out_nxt  = is_nan_out;
        is_pinf_out_nxt = is_pinf_out;

        if (enable) begin
            result_nxt   = 1'b0;
            it_valid_nxt = 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        it_valid_nxt = 1'b1;
                        if (op_nan) begin
                            result_nxt      = 1'b1;
                            sign_out_nxt    = sign_in;
                            exp_out_nxt     = EXP_SPEC;
                            mant_out_nxt    = mant_in | QUIET_BIT;
                            is_nan_out_nxt  = 1'b1;
                            is_pinf_out_nxt = 1'b0;
                        end else if (op_inf) begin
                            result_nxt      = 1'b1;
                            sign_out_nxt    = 1'b0;
                            exp_out_nxt     = EXP_SPEC;
                            mant_out_nxt    = MANT_ONE;
                            is_nan_out_nxt  = 1'b0;
                            is_pinf_out_nxt = 1'b1;
                        end else if (op_zero) begin
                            // Any zero/subnormal squared is below 2^-14.
                            result_nxt      = 1'b1;
                            sign_out_nxt    = 1'b0;
                            exp_out_nxt     = EXP_ZERO;
                            mant_out_nxt    = 11'd0;
                            is_nan_out_nxt  = 1'b0;
                            is_pinf_out_nxt = 1'b0;
                        end else begin
                            state_nxt       = ST_BUSY;
                            iter_nxt        = ITER_STEPS;
                            mcand_nxt       = {11'd0, mant_in};
                            mplier_nxt      = mant_in;
                            acc_nxt         = 22'd0;
                            exp_lat_nxt     = exp_in;
                            is_nan_out_nxt  = 1'b0;
                            is_pinf_out_nxt = 1'b0;
                        end
                    end
                end

                ST_BUSY: begin
                    it_valid_nxt = 1'b1;
                    acc_nxt      = prod;
                    mcand_nxt    = {mcand[20:0], 1'b0};
                    mplier_nxt   = {1'b0, mplier[10:1]};
                    iter_nxt     = iter - 4'd1;

                    if (iter == 4'd1) begin
                        state_nxt    = ST_IDLE;
                        result_nxt   = 1'b1;
                        sign_out_nxt = 1'b0;
                        if (e_sq > 8'sd15) begin
                            exp_out_nxt     = EXP_SPEC;
                            mant_out_nxt    = MANT_ONE;
                            is_pinf_out_nxt = 1'b1;
                        end else if (e_sq < -8'sd14) begin
                            exp_out_nxt     = EXP_ZERO;
                            mant_out_nxt    = 11'd0;
                        end else begin
                            exp_out_nxt     = e_sq[6:0];
                            mant_out_nxt    = mant_norm;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter        <= 4'd0;
            mcand       <= 22'd0;
            mplier      <= 11'd0;
            acc         <= 22'd0;
            exp_lat     <= 7'sd0;
            it_valid    <= 1'b0;
            result      <= 1'b0;
            sign_out    <= 1'b0;
            exp_out     <= 7'sd0;
            mant_out    <= 11'd0;
            is_nan_out  <= 1'b0;
            is_pinf_out <= 1'b0;
        end else begin
            iter        <= iter_nxt;
            mcand       <= mcand_nxt;
            mplier      <= mplier_nxt;
            acc         <= acc_nxt;
            exp_lat     <= exp_lat_nxt;
            it_valid    <= it_valid_nxt;
            result      <= result_nxt;
            sign_out    <= sign_out_nxt;
            exp_out     <= exp_out_nxt;
            mant_out    <= mant_out_nxt;
            is_nan_out  <= is_nan_out_nxt;
            is_pinf_out <= is_pinf_out_nxt;
        end
    end

    assign is_ninf_out = 1'b0;

endmodule

// File: tb/tb_square_iterate.sv
module tb_square_iterate;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b1;
    logic              n_valid = 1'b0;
    logic              is_nan_in = 1'b0;
    logic              is_pinf_in = 1'b0;
    logic              is_ninf_in = 1'b0;
    logic              is_num = 1'b1;
    logic              sign_in = 1'b0;
    logic signed [6:0] exp_in = 7'sd0;
    logic [10:0]       mant_in = 11'd0;
    logic              it_valid, result, sign_out;
    logic signed [6:0] exp_out;
    logic [10:0]       mant_out;
    logic              is_nan_out, is_pinf_out, is_ninf_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    square_iterate dut (
        .clk(clk), .rst(rst), .enable(enable), .n_valid(n_valid),
        .is_nan_in(is_nan_in), .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in),
        .is_num(is_num), .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
        .it_valid(it_valid), .result(result), .sign_out(sign_out),
        .exp_out(exp_out), .mant_out(mant_out), .is_nan_out(is_nan_out),
        .is_pinf_out(is_pinf_out), .is_ninf_out(is_ninf_out)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    endtask

    // Square of an unpacked operand computed directly from the number rules.
    function automatic void sq_model(
        input bit nan_f, input bit pinf_f, input bit ninf_f, input bit num_f,
        input bit s, input int e_in, input int m_in,
        output bit special, output int r_sign, output int r_exp,
        output int r_mant, output int r_nan, output int r_pinf);
        int p, e;
        special = 1'b1; r_sign = 0; r_nan = 0; r_pinf = 0;
        if (nan_f || (!num_f && !pinf_f && !ninf_f)) begin
            r_sign = s; r_exp = 16; r_mant = m_in | 512; r_nan = 1;
        end else if (pinf_f || ninf_f) begin
            r_exp = 16; r_mant = 1024; r_pinf = 1;
        end else if (e_in == -15) begin
            r_exp = -15; r_mant = 0;
        end else begin
            special = 1'b0;
            p = m_in * m_in;
            e = 2 * e_in;
            if (p >= (1 << 21)) begin r_mant = p / 2048; e = e + 1; end
            else r_mant = p / 1024;
            r_exp = e;
            if (e > 15) begin r_exp = 16; r_mant = 1024; r_pinf = 1; end
            else if (e < -14) begin r_exp = -15; r_mant = 0; end
        end
    endfunction

    // Expected outputs after each edge, tracked at transaction level.
    int m_it = 0, m_result = 0, m_sign = 0, m_exp = 0, m_mant = 0, m_nan = 0, m_pinf = 0;
    int p_exp = 0, p_mant = 0, p_pinf = 0;
    int m_left = 0;
    bit m_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit sp;
        int rs, re, rm, rn, rp;
        if (rst) begin
            m_it = 0; m_result = 0; m_sign = 0; m_exp = 0; m_mant = 0;
            m_nan = 0; m_pinf = 0; m_busy = 1'b0; m_left = 0;
        end else if (enable) begin
            m_result = 0;
            if (m_busy) begin
                m_it = 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_result = 1;
                    m_sign = 0; m_exp = p_exp; m_mant = p_mant; m_pinf = p_pinf; m_nan = 0;
                end
            end else if (n_valid) begin
                m_it = 1;
                sq_model(is_nan_in, is_pinf_in, is_ninf_in, is_num, sign_in,
                         int'(exp_in), int'(mant_in), sp, rs, re, rm, rn, rp);
                if (sp) begin
                    m_result = 1; m_sign = rs; m_exp = re; m_mant = rm; m_nan = rn; m_pinf = rp;
                end else begin
                    m_busy = 1'b1; m_left = 11;
                    p_exp = re; p_mant = rm; p_pinf = rp;
                    m_nan = 0; m_pinf = 0;
                end
            end else begin
                m_it = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_it_valid", int'(it_valid), m_it);
            chk("cyc_result", int'(result), m_result);
            chk("cyc_sign", int'(sign_out), m_sign);
            chk("cyc_exp", int'(exp_out), m_exp);
            chk("cyc_mant", int'(mant_out), m_mant);
            chk("cyc_nan", int'(is_nan_out), m_nan);
            chk("cyc_pinf", int'(is_pinf_out), m_pinf);
            chk("cyc_ninf", int'(is_ninf_out), 0);
        end
    end

    task automatic set_op(input bit nan_f, input bit pinf_f, input bit ninf_f, input bit num_f,
                          input bit s, input logic signed [6:0] e, input logic [10:0] m);
        is_nan_in = nan_f; is_pinf_in = pinf_f; is_ninf_in = ninf_f; is_num = num_f;
        sign_in = s; exp_in = e; mant_in = m;
    endtask

    // Present the operand for one edge; returns just after E0.
    task automatic issue();
        n_valid = 1'b1;
        @(negedge clk);
        n_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result && n < 40);
        if (!result) chk({name, "_timeout"}, int'(result), 1);
    endtask

    initial begin
        int n;
        bit sp;
        int rs, re, rm, rn, rp;

        // Pin the model against hand-computed squares.
        sq_model(0, 0, 0, 1, 0, 0, 1536, sp, rs, re, rm, rn, rp);
        chk("model_1p5_exp", re, 1);
        chk("model_1p5_mant", rm, 1152);
        sq_model(0, 0, 0, 1, 0, 8, 1024, sp, rs, re, rm, rn, rp);
        chk("model_2e8_pinf", rp, 1);
        sq_model(0, 0, 0, 1, 0, -8, 1024, sp, rs, re, rm, rn, rp);
        chk("model_2em8_exp", re, -15);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_it_valid", int'(it_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_exp", int'(exp_out), 0);
        chk("rst_mant", int'(mant_out), 0);
        cmp_on = 1'b1;
        @(negedge clk);

        // 1.5^2
        set_op(0, 0, 0, 1, 0, 7'sd0, 11'b110_0000_0000);
        issue();
        wait_result("sq1p5", n);
        chk("sq1p5_latency", n, 11);
        chk("sq1p5_exp", int'(exp_out), 1);
        chk("sq1p5_mant", int'(mant_out), 11'b100_1000_0000);
        chk("sq1p5_sign", int'(sign_out), 0);
        @(negedge clk);
        chk("sq1p5_it_low", int'(it_valid), 0);

        // -3.0^2 then 1.0^2 with n_valid held through E11
        set_op(0, 0, 0, 1, 1, 7'sd1, 11'b110_0000_0000);
        n_valid = 1'b1;
        @(negedge clk);
        set_op(0, 0, 0, 1, 0, 7'sd0, 11'b100_0000_0000);
        wait_result("sq3", n);
        chk("sq3_latency", n, 11);
        chk("sq3_exp", int'(exp_out), 3);
        chk("sq3_mant", int'(mant_out), 11'b100_1000_0000);
        chk("sq3_sign", int'(sign_out), 0);
        @(negedge clk);
        chk("b2b_accept_it", int'(it_valid), 1);
        chk("b2b_accept_res", int'(result), 0);
        n_valid = 1'b0;
        wait_result("sq1", n);
        chk("sq1_latency", n, 11);
        chk("sq1_exp", int'(exp_out), 0);
        chk("sq1_mant", int'(mant_out), 11'b100_0000_0000);
        @(negedge clk);

        // Range limits
        set_op(0, 0, 0, 1, 0, 7'sd8, 11'b100_0000_0000);
        issue();
        wait_result("ovf", n);
        chk("ovf_exp", int'(exp_out), 16);
        chk("ovf_pinf", int'(is_pinf_out), 1);
        chk("ovf_mant", int'(mant_out), 11'b100_0000_0000);
        @(negedge clk);
        set_op(0, 0, 0, 1, 0, -7'sd8, 11'b100_0000_0000);
        issue();
        wait_result("unf", n);
        chk("unf_exp", int'(exp_out), -15);
        chk("unf_mant", int'(mant_out), 0);
        chk("unf_pinf", int'(is_pinf_out), 0);
        @(negedge clk);

        // Specials resolve on E0
        set_op(0, 0, 1, 0, 1, 7'sd16, 11'b100_0000_0000);
        issue();
        chk("ninf_result", int'(result), 1);
        chk("ninf_pinf", int'(is_pinf_out), 1);
        chk("ninf_sign", int'(sign_out), 0);
        // A pending pulse holds while disabled
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_pulse", int'(result), 1);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("pulse_drop", int'(result), 0);
        chk("pulse_it_drop", int'(it_valid), 0);

        set_op(1, 0, 0, 0, 1, 7'sd16, 11'b100_0000_0101);
        issue();
        chk("nan_result", int'(result), 1);
        chk("nan_sign", int'(sign_out), 1);
        chk("nan_exp", int'(exp_out), 16);
        chk("nan_mant", int'(mant_out), 11'b110_0000_0101);
        chk("nan_flag", int'(is_nan_out), 1);
        @(negedge clk);

        set_op(0, 0, 0, 1, 1, -7'sd15, 11'd5);
        issue();
        chk("zero_result", int'(result), 1);
        chk("zero_exp", int'(exp_out), -15);
        chk("zero_mant", int'(mant_out), 0);
        chk("zero_nan", int'(is_nan_out), 0);
        @(negedge clk);

        // Enable gap of 5 cycles after E4
        set_op(0, 0, 0, 1, 0, 7'sd0, 11'b110_0000_0000);
        issue();
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("gap_it_valid", int'(it_valid), 1);
            chk("gap_result", int'(result), 0);
        end
        enable = 1'b1;
        wait_result("gap", n);
        chk("gap_latency", n + 9, 16);
        chk("gap_mant", int'(mant_out), 11'b100_1000_0000);
        chk("gap_exp", int'(exp_out), 1);
        @(negedge clk);

        // Reset mid-computation
        set_op(0, 0, 0, 1, 0, 7'sd0, 11'b110_0000_0000);
        issue();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_it_valid", int'(it_valid), 0);
        chk("arst_exp", int'(exp_out), 0);
        chk("arst_mant", int'(mant_out), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            chk("arst_no_result", int'(result), 0);
        end
        set_op(0, 0, 0, 1, 0, 7'sd0, 11'b100_0000_0000);
        issue();
        wait_result("post_rst", n);
        chk("post_rst_latency", n, 11);
        chk("post_rst_mant", int'(mant_out), 11'b100_0000_0000);
        chk("post_rst_exp", int'(exp_out), 0);
        @(negedge clk);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/square_iterate.md
# square_iterate

Iterative floating-point squarer for the 16-bit unpacked number path; the inverse operation of the sqrt iteration unit. It takes a number already unpacked into sign, unbiased exponent, 11-bit mantissa and class flags. It computes the square with an 11-step shift-add loop. It then returns the result on the same field and flag bundle used by the sqrt unit, so downstream packing logic is shared.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- enable  in  1  clock enable; when 0 every register holds
- n_valid  in  1  operand present; accepted only when idle
- is_nan_in / is_pinf_in / is_ninf_in  in  1 each  operand class flags
- is_num  in  1  operand is finite (zero, subnormal or normal)
- sign_in  in  1  operand sign
- exp_in  in  7 signed  unbiased exponent; -15 means zero/subnormal, 16 means Inf/NaN
- mant_in  in  11  mantissa; bit 10 is the integer bit, bit 9 is the NaN quiet bit
- it_valid  out  1  unit busy or has just accepted an operand
- result  out  1  one-cycle pulse; output fields are final
- sign_out  out  1; exp_out  out  7 signed; mant_out  out  11  result fields
- is_nan_out / is_pinf_out / is_ninf_out  out  1 each  result class flags

## Operation
- Start: start = enable & n_valid & !active. While active, n_valid is ignored and never queued.
- Special classification at start:
  - NaN: is_nan_in=1, or is_num=0 with no flag set.
  - Inf: is_pinf_in or is_ninf_in.
  - Zero/subnormal: exp_in = -15. Any square of such a value is below 2^-14, so it flushes to zero.
- Special results, registered at the start edge with result=1 and no iteration:
  - NaN: sign_out=sign_in, exp_out=16, mant_out=mant_in with bit 9 forced to 1, is_nan_out=1.
  - ±Inf: sign_out=0, exp_out=16, mant_out=11'b10000000000, is_pinf_out=1.
  - Zero/subnormal: sign_out=0, exp_out=-15, mant_out=0, all flags 0.
- Numeric start:
  - Load multiplicand=mant_in, multiplier=mant_in, 22-bit accumulator=0.
  - Latch exp_in, set iter=11, set active=1.
  - Clear all out flags. sign_out, exp_out and mant_out hold their old values.
- Each enabled active cycle:
  - If multiplier bit 0 = 1, add the multiplicand, aligned by step, into the accumulator.
  - Shift the multiplier right by one and decrement iter.
- Final step (iter==1): normalize P = mant×mant, 22 bits.
  - If P[21]=1: mant_out=P[21:11], e=2·exp+1.
  - Else: mant_out=P[20:10], e=2·exp.
  - Truncate; no rounding.
  - Compute e in 8-bit signed arithmetic.
  - If e>15: +Inf encoding with is_pinf_out=1.
  - If e<-14: zero encoding.
  - Otherwise exp_out=e[6:0].
  - sign_out=0, result=1, active=0.
- is_ninf_out is never set by this block. It stays 0 after reset.
- Outputs and flags hold until the next accepted start.

## Timing
- Reset values: all outputs 0; active=0, iter=0, accumulator=0.
- Reset asserted mid-computation aborts it; no result pulse follows.
- Special latency: the start edge E0 registers result=1 and it_valid=1. Both drop at E1 unless a new start occurs.
- Numeric latency (enabled edges only):
  - E0 accepts the operand.
  - E1..E11 perform iterations. E11 registers result=1 and final fields.
  - it_valid=1 from E0 through E11 and drops at E12 unless a new start occurs.
- Back-to-back numeric throughput: one operand per 12 enabled cycles.
  - n_valid at E11 is ignored because active is still 1.
  - n_valid at E12 is accepted.
- enable=0 freezes all state, outputs included. A pending result pulse stays asserted until the next enabled edge. Latency counts only enabled cycles.
- result is 1 only on the cycle following its registering edge. It is never asserted without a matching start.

## Test plan
- 1.5²: exp_in=0, mant_in=11'b11000000000 -> result at E11 with sign_out=0, exp_out=1, mant_out=11'b10010000000 (2.25), no flags, it_valid low at E12.
- 3.0² with sign_in=1, and 1.0² issued back-to-back at E12:
  - 3.0²: exp_in=1, mant_in=11'b11000000000 -> exp_out=3, mant_out=11'b10010000000, sign_out=0.
  - The second operand is accepted at E12, and 1.0² gives exp_out=0, mant_out=11'b10000000000 at E23.
  - n_valid held high at E11 must not start an operation.
- Range limits:
  - 2^8 (exp_in=8, mant_in=11'b10000000000) -> exp_out=16, mant_out=11'b10000000000, is_pinf_out=1.
  - 2^-8 -> exp_out=-15, mant_out=0.
- Specials (result at E0, latency 1):
  - -Inf -> +Inf with is_pinf_out=1.
  - NaN with sign_in=1, mant_in=11'b10000000101 -> sign_out=1, exp_out=16, mant_out=11'b11000000101, is_nan_out=1.
  - exp_in=-15, mant_in=5 -> zero.
- enable=0 for 5 cycles after E4 of a 1.5² computation -> identical result delayed by 5 cycles, with all outputs frozen during the gap.
- rst pulsed at E6 of a computation -> all outputs 0 immediately. No result pulse follows. A new n_valid after reset is accepted and completes normally.
